// File: rtl/clock_ctrl_pkg.sv
// Shared types and default parameters for the run/step/halt clock-enable controller.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        S_STEP = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } clk_state_t;

    localparam int RUN_DIV_DEF    = 4;
    localparam int DIV_W_DEF      = 24;
    localparam int DEB_CYCLES_DEF = 8;
    localparam int TICK_W_DEF     = 16;

endpackage

// File: rtl/clock_ctrl_btn_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, stability filter, clean level and rise pulse.
module btn_debounce
    import clock_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q counts consecutive synced samples that disagree with the accepted level
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/clock_ctrl.sv
// Run/step/halt controller producing the CPU clock-enable pulse.
// Optional tick counter enabled by defining CLOCK_CTRL_TICK_CNT_EN.
module clock_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int RUN_DIV    = RUN_DIV_DEF,
    parameter int DIV_W      = DIV_W_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int TICK_W     = TICK_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run_mode,
    input  logic              step_btn,
    input  logic              halt,
    input  logic              resume,
    output logic              clk_en,
    output logic              halted,
    output logic              run_active,
    output logic [TICK_W-1:0] tick_count
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    logic             run_sync1_q, run_sync2_q;
    logic             btn_level, btn_rise;
    clk_state_t       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             clk_en_q, clk_en_d;
    logic             halted_q, halted_d;
    logic             run_active_q, run_active_d;
    logic             fire;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (step_btn),
        .level   (btn_level),
        .rise    (btn_rise)
    );

    // halt outranks a mode change, which outranks any pulse due this cycle
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        fire    = 1'b0;
        if (halt) begin
            state_d = S_HALT;
            div_d   = '0;
        end else begin
            case (state_q)
                S_STEP: begin
                    if (run_sync2_q) begin
                        state_d = S_RUN;
                        div_d   = '0;
                    end else if (btn_rise && btn_level) begin
                        fire = 1'b1;
                    end
                end
                S_RUN: begin
                    if (!run_sync2_q) begin
                        state_d = S_STEP;
                        div_d   = '0;
                    end else if (div_q == DIV_LAST) begin
                        fire  = 1'b1;
                        div_d = '0;
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                S_HALT: begin
                    if (resume) begin
                        state_d = run_sync2_q ? S_RUN : S_STEP;
                        div_d   = '0;
                    end
                end
                default: begin
                    state_d = S_STEP;
                    div_d   = '0;
                end
            endcase
        end
        clk_en_d     = fire;
        halted_d     = (state_d == S_HALT);
        run_active_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_sync1_q  <= 1'b0;
            run_sync2_q  <= 1'b0;
            state_q      <= S_STEP;
            div_q        <= '0;
            clk_en_q     <= 1'b0;
            halted_q     <= 1'b0;
            run_active_q <= 1'b0;
        end else begin
            run_sync1_q  <= run_mode;
            run_sync2_q  <= run_sync1_q;
            state_q      <= state_d;
            div_q        <= div_d;
            clk_en_q     <= clk_en_d;
            halted_q     <= halted_d;
            run_active_q <= run_active_d;
        end
    end

    assign clk_en     = clk_en_q;
    assign halted     = halted_q;
    assign run_active = run_active_q;

`ifdef CLOCK_CTRL_TICK_CNT_EN
    logic [TICK_W-1:0] tick_q, tick_d;

    // counts together with the pulse so tick_count already includes a visible clk_en
    always_comb begin
        tick_d = tick_q;
        if (clk_en_d) begin
            tick_d = tick_q + TICK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tick_count = tick_q;
`else
    assign tick_count = '0;
`endif

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl: a cycle model compared every cycle plus directed literal checks.
module tb_clock_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run_mode = 1'b0;
    logic        step_btn = 1'b0;
    logic        halt = 1'b0;
    logic        resume = 1'b0;
    logic        en4, halted4, run4, en1, halted1, run1;
    logic [15:0] tick4, tick1;

    int n_checks = 0;
    int n_fail = 0;
    int p4 = 0;
    int p1 = 0;

    always #5 clk = ~clk;

    clock_ctrl #(.RUN_DIV(4), .DIV_W(24), .DEB_CYCLES(8), .TICK_W(16)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .run_mode(run_mode), .step_btn(step_btn),
        .halt(halt), .resume(resume), .clk_en(en4), .halted(halted4),
        .run_active(run4), .tick_count(tick4)
    );

    clock_ctrl #(.RUN_DIV(1), .DIV_W(24), .DEB_CYCLES(8), .TICK_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .run_mode(run_mode), .step_btn(step_btn),
        .halt(halt), .resume(resume), .clk_en(en1), .halted(halted1),
        .run_active(run1), .tick_count(tick1)
    );

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_r1, m_r2, m_b1, m_b2;
    bit          m_hist[$];
    logic        m_level, m_rise;
    logic        m_halted, m_running;
    int          m_age;
    logic        m_en4, m_en1;
    logic [15:0] m_tick4, m_tick1;
    bit          f4, f1, all_eq;

    task automatic model_reset();
        m_r1 = 0; m_r2 = 0; m_b1 = 0; m_b2 = 0;
        m_hist.delete();
        m_level = 0; m_rise = 0;
        m_halted = 0; m_running = 0; m_age = 0;
        m_en4 = 0; m_en1 = 0; m_tick4 = 0; m_tick1 = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                f4 = 0;
                f1 = 0;
                if (halt) begin
                    m_halted = 1;
                    m_running = 0;
                end else if (m_halted) begin
                    if (resume) begin
                        m_halted = 0;
                        m_running = m_r2;
                        m_age = 0;
                    end
                end else if (m_running) begin
                    if (!m_r2) begin
                        m_running = 0;
                    end else begin
                        f4 = ((m_age % 4) == 3);
                        f1 = 1;
                        m_age++;
                    end
                end else begin
                    if (m_r2) begin
                        m_running = 1;
                        m_age = 0;
                    end else if (m_rise) begin
                        f4 = 1;
                        f1 = 1;
                    end
                end
                m_en4 = f4;
                m_en1 = f1;
                if (f4) m_tick4 = m_tick4 + 16'd1;
                if (f1) m_tick1 = m_tick1 + 16'd1;
                // debounced level: last 8 synced samples all agree and differ from the level
                m_hist.push_back(m_b2);
                if (m_hist.size() > 8) void'(m_hist.pop_front());
                m_rise = 0;
                if (m_hist.size() == 8) begin
                    all_eq = 1;
                    foreach (m_hist[k]) if (m_hist[k] != m_hist[0]) all_eq = 0;
                    if (all_eq && (m_hist[0] != m_level)) begin
                        m_level = m_hist[0];
                        m_rise = m_level;
                    end
                end
                m_b2 = m_b1;
                m_b1 = step_btn;
                m_r2 = m_r1;
                m_r1 = run_mode;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            check1("cyc_en4", en4, m_en4);
            check1("cyc_halted4", halted4, m_halted);
            check1("cyc_run4", run4, m_running);
            check1("cyc_en1", en1, m_en1);
            check1("cyc_halted1", halted1, m_halted);
            check1("cyc_run1", run1, m_running);
`ifdef CLOCK_CTRL_TICK_CNT_EN
            check1("cyc_tick4", tick4, m_tick4);
            check1("cyc_tick1", tick1, m_tick1);
`else
            check1("cyc_tick4", tick4, 0);
            check1("cyc_tick1", tick1, 0);
`endif
        end
    end

    task automatic step_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (en4) p4++;
            if (en1) p1++;
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int found;
        step_cycles(3);
        check1("rst_en", en4, 0);
        check1("rst_halted", halted4, 0);
        check1("rst_run", run4, 0);
        check1("rst_tick", tick4, 0);
        rst_n = 1'b1;
        step_cycles(2);

        // 1: bouncy press, long hold, bouncy release -> exactly one pulse
        p4 = 0; p1 = 0;
        for (int i = 0; i < 6; i++) begin
            step_btn = ((i % 2) == 0);
            step_cycles(2);
        end
        step_btn = 1'b1;
        step_cycles(40);
        for (int i = 0; i < 4; i++) begin
            step_btn = ((i % 2) == 1);
            step_cycles(2);
        end
        step_btn = 1'b0;
        step_cycles(20);
        $display("step press: pulses dut4=%0d dut1=%0d", p4, p1);
        check1("step_pulses4", p4, 1);
        check1("step_pulses1", p1, 1);
`ifdef CLOCK_CTRL_TICK_CNT_EN
        check1("step_tick", tick4, 1);
`else
        check1("step_tick", tick4, 0);
`endif

        // 2: free run, 40 cycles
        run_mode = 1'b1;
        step_cycles(8);
        p4 = 0; p1 = 0;
        step_cycles(40);
        $display("run 40 cycles: pulses dut4=%0d dut1=%0d", p4, p1);
        check1("run_pulses4", p4, 10);
        check1("run_pulses1", p1, 40);
        check1("run_active", run4, 1);

        // 3: halt on the cycle a pulse is due
        found = 0;
        for (int k = 0; k < 8 && found == 0; k++) begin
            if (m_running && (m_age % 4) == 3) found = 1;
            else step_cycles(1);
        end
        check1("halt_due_found", found, 1);
        halt = 1'b1;
        step_cycles(1);
        $display("halt on due cycle: en4=%0b halted4=%0b", en4, halted4);
        check1("halt_suppress", en4, 0);
        check1("halt_flag", halted4, 1);
        p4 = 0; p1 = 0;
        step_cycles(20);
        check1("halt_quiet4", p4, 0);
        check1("halt_quiet1", p1, 0);

        // 4: resume with halt still high is ignored, then real resume
        resume = 1'b1;
        step_cycles(1);
        check1("resume_ignored", halted4, 1);
        halt = 1'b0;
        step_cycles(1);
        resume = 1'b0;
        check1("resume_halted", halted4, 0);
        check1("resume_run", run4, 1);
        check1("resume_en0", en4, 0);
        for (int i = 1; i <= 4; i++) begin
            step_cycles(1);
            $display("resume cycle %0d: en4=%0b", i, en4);
            check1("resume_first_pulse", en4, (i == 4));
        end

        // 5: RUN_DIV=1 continuous, then drop run_mode
        step_cycles(4);
        check1("div1_high", en1, 1);
        run_mode = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step_cycles(1);
            $display("run_mode drop cycle %0d: en1=%0b", i, en1);
            check1("div1_drop", en1, (i <= 2));
        end
        check1("div1_step", run1, 0);

        // 6: reset mid-pulse
        run_mode = 1'b1;
        step_cycles(6);
        found = 0;
        for (int k = 0; k < 8 && found == 0; k++) begin
            if (en4) found = 1;
            else step_cycles(1);
        end
        check1("pulse_found", found, 1);
        #1;
        rst_n = 1'b0;
        run_mode = 1'b0;
        #1;
        $display("reset mid-pulse: en4=%0b run4=%0b tick4=%0d", en4, run4, tick4);
        check1("arst_en4", en4, 0);
        check1("arst_en1", en1, 0);
        check1("arst_halted", halted4, 0);
        check1("arst_run", run4, 0);
        check1("arst_tick4", tick4, 0);
        check1("arst_tick1", tick1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        p4 = 0; p1 = 0;
        step_cycles(10);
        check1("post_rst_run", run4, 0);
        check1("post_rst_halted", halted4, 0);
        check1("post_rst_pulses", p4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
